pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Run/step/halt controller for the 5-stage MIPS pipeline. It gates the PC and the pipeline registers from host debug commands: continuous run, single step and pause. It detects the HALT instruction at fetch, blocks further fetch and drains the in-flight instructions before reporting halted. It sits between the debug command interface and the IF/ID/EX/MEM/WB register enables, alongside the instruction decoder.

## Interface
- `PIPE_DEPTH`, default 4: drain cycles after HALT is fetched (ID, EX, MEM, WB).
- `CNT_W`, default 32: width of the executed-cycle counter.
- `HALT_INSTR`, default 32'hFFFF_FFFF: encoding of the HALT instruction.

- `clk`: input, 1. Single clock, all state updates on the rising edge.
- `reset`: input, 1. Synchronous, active-high.
- `i_cmd_valid`: input, 1. Host command strobe.
- `i_cmd`: input, 2. 01 RUN, 10 STEP, 11 PAUSE, 00 reserved (ignored).
- `o_cmd_ready`: output, 1. Command accepted when `i_cmd_valid && o_cmd_ready`.
- `i_if_instr`: input, 32. Instruction currently at the IF stage output.
- `o_pc_en`: output, 1. PC update enable.
- `o_pipe_en`: output, 1. Enable for all pipeline registers.
- `o_flush_if`: output, 1. Forces NOP (32'b0) into IF/ID.
- `o_step_done`: output, 1. One-cycle pulse when a step completes.
- `o_halted`: output, 1. High in HALTED.
- `o_cycle_cnt`: output, CNT_W. Count of cycles with `o_pipe_en` high.

## Operation
- FSM states: IDLE, RUN, STEP, DRAIN, HALTED.
- `halt_hit` = (`i_if_instr` == HALT_INSTR). Outputs are combinational from state and `halt_hit`; state and counters are registered.
- **IDLE**
  - `pipe_en`=0, `pc_en`=0, `flush_if`=0, `cmd_ready`=1.
  - RUN goes to RUN. STEP goes to STEP. PAUSE and 00 are accepted with no effect.
- **RUN**
  - `pipe_en`=1, `cmd_ready`=1.
  - If `halt_hit`: `pc_en`=0, `flush_if`=1, go to DRAIN with `drain_cnt`=PIPE_DEPTH-1.
  - Else `pc_en`=1.
  - An accepted PAUSE without `halt_hit` goes to IDLE. The current cycle still executes, so PAUSE takes effect from the next cycle.
  - `halt_hit` takes priority over PAUSE in the same cycle.
- **STEP**
  - Exactly one cycle: `pipe_en`=1, `cmd_ready`=0, `o_step_done`=1.
  - If `halt_hit`: `pc_en`=0, `flush_if`=1, go to DRAIN with `drain_cnt`=PIPE_DEPTH-1.
  - Else `pc_en`=1, go to IDLE.
- **DRAIN**
  - `pipe_en`=1, `pc_en`=0, `flush_if`=1, `cmd_ready`=0.
  - `drain_cnt` decrements each cycle. When `drain_cnt`==0 in DRAIN, go to HALTED.
  - `i_if_instr` is ignored.
- **HALTED**
  - `pipe_en`=0, `pc_en`=0, `flush_if`=0, `cmd_ready`=0, `o_halted`=1.
  - Left only via `reset`. All commands are ignored, with no handshake.
- **Cycle counter**
  - `o_cycle_cnt` += 1 on every cycle with `o_pipe_en`=1.
  - Saturates at 2^CNT_W-1 and never wraps.
- **Drain counter width**: $clog2(PIPE_DEPTH)+1. PIPE_DEPTH=1 gives a single DRAIN cycle.

## Timing
- Reset values: state IDLE, `o_pc_en`=0, `o_pipe_en`=0, `o_flush_if`=0, `o_step_done`=0, `o_halted`=0, `o_cycle_cnt`=0, `o_cmd_ready`=1, `drain_cnt`=0.
- Reset asserted mid-RUN or mid-DRAIN: state returns to IDLE on the next edge and the counter is cleared. Reset has priority over every command.
- Command latency: command accepted at edge N, so the new state's outputs appear in cycle N+1.
  - RUN accepted in cycle N gives the first `pipe_en`=1 in cycle N+1.
  - STEP gives exactly one `pipe_en` cycle (N+1) and the FSM is back in IDLE at N+2.
- HALT fetched in cycle H (RUN or STEP):
  - `pc_en`=0 and `flush_if`=1 in cycles H to H+PIPE_DEPTH.
  - `o_halted`=1 from cycle H+PIPE_DEPTH+1.
  - Total `pipe_en` cycles from H onward = PIPE_DEPTH+1.
- `o_cmd_ready`=0 in STEP, DRAIN and HALTED. `i_cmd_valid` in those states is dropped, not queued.
- `o_step_done` is high only during the STEP cycle, never in RUN or DRAIN.

## Test plan
- **Reset defaults.** Hold `reset` for 2 cycles, then release with `i_cmd_valid`=0 for 10 cycles: all outputs stay at reset values, `o_cmd_ready`=1, `o_cycle_cnt`=0.
- **Run then pause.** RUN at cycle 0, non-HALT instructions, PAUSE accepted at cycle 10: `pipe_en`/`pc_en` high in cycles 1–10, low from 11, `o_cycle_cnt`=10.
- **Three steps.** Three STEP commands spaced 3 cycles apart: three single-cycle `pipe_en`+`step_done` pulses, `o_cycle_cnt`=3. A STEP presented during the STEP cycle sees `cmd_ready`=0 and is dropped.
- **Halt drain, PIPE_DEPTH=4.** RUN, HALT_INSTR at IF in cycle 7:
  - `pc_en`=1 in cycles 1–6, low from 7.
  - `flush_if`=1 in cycles 7–11.
  - `pipe_en` low from 12, `o_halted`=1 from 12, `o_cycle_cnt`=11.
  - Later RUN/STEP commands are ignored.
- **Simultaneous HALT and PAUSE.** PAUSE accepted in the cycle `halt_hit`=1: FSM goes to DRAIN, not IDLE, and ends in HALTED.
- **Saturation and reset mid-DRAIN.**
  - CNT_W=4, RUN for 20 cycles: counter stops at 15.
  - Reset asserted during DRAIN: IDLE next cycle, `o_halted` never asserts.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline: gates PC and pipeline
// register enables from host debug commands and drains after a fetched HALT.
module pipeline_sequencer #(
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic [31:0]      i_if_instr,
  output logic             o_pc_en,
  output logic             o_pipe_en,
  output logic             o_flush_if,
  output logic             o_step_done,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int unsigned DRAIN_W = $clog2(PIPE_DEPTH) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t               r_state;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [CNT_W-1:0]     r_cycle_cnt;
  logic                 w_halt_hit;
  logic                 w_cmd_acc;

  assign w_halt_hit  = (i_if_instr == HALT_INSTR);
  assign w_cmd_acc   = i_cmd_valid && o_cmd_ready;
  assign o_cycle_cnt = r_cycle_cnt;

  // Enables react to HALT in the same cycle it is fetched, so they are decoded
  // from the current state plus halt_hit rather than registered.
  always_comb begin
    o_pipe_en   = 1'b0;
    o_pc_en     = 1'b0;
    o_flush_if  = 1'b0;
    o_cmd_ready = 1'b0;
    o_step_done = 1'b0;
    o_halted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
      end
      S_RUN: begin
        o_pipe_en   = 1'b1;
        o_cmd_ready = 1'b1;
        o_pc_en     = !w_halt_hit;
        o_flush_if  = w_halt_hit;
      end
      S_STEP: begin
        o_pipe_en   = 1'b1;
        o_step_done = 1'b1;
        o_pc_en     = !w_halt_hit;
        o_flush_if  = w_halt_hit;
      end
      S_DRAIN: begin
        o_pipe_en  = 1'b1;
        o_flush_if = 1'b1;
      end
      S_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        o_cmd_ready = 1'b0;
      end
    endcase
  end

  // State, drain countdown and executed-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (o_pipe_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc && (i_cmd == CMD_RUN)) begin
            r_state <= S_RUN;
          end else if (w_cmd_acc && (i_cmd == CMD_STEP)) begin
            r_state <= S_STEP;
          end
        end
        S_RUN: begin
          if (w_halt_hit) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end else if (w_cmd_acc && (i_cmd == CMD_PAUSE)) begin
            r_state <= S_IDLE;
          end
        end
        S_STEP: begin
          if (w_halt_hit) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_HALTED;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
